// File: rtl/gc_joybus_pkg.sv
// gc_joybus_pkg: shared types and constants for the Joybus command transmitter
// Holds the cmd_sel and FSM state enums, the command bytes, the per-bit
// quarter patterns (bit 3 = first quarter on the wire) and the frame builder.
package gc_joybus_pkg;

    typedef enum logic [1:0] {SEL_PROBE, SEL_ORIGIN, SEL_POLL, SEL_RECAL} cmd_sel_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_STOP, ST_GUARD} state_e;

    localparam logic [7:0] CMD_PROBE  = 8'h00;
    localparam logic [7:0] CMD_ORIGIN = 8'h41;
    localparam logic [7:0] CMD_POLL   = 8'h40;
    localparam logic [7:0] CMD_RECAL  = 8'h42;

    localparam logic [3:0] Q_BIT0 = 4'b0001;
    localparam logic [3:0] Q_BIT1 = 4'b0111;
    localparam logic [3:0] Q_STOP = 4'b0111;

    // Frame left-aligned in 24 bits so the serializer always shifts out bit 23.
    function automatic logic [23:0] frame_word(cmd_sel_e sel, logic [7:0] mode, logic rum);
        return sel == SEL_POLL ? {CMD_POLL, mode, 7'd0, rum} :
               {sel == SEL_PROBE ? CMD_PROBE : sel == SEL_ORIGIN ? CMD_ORIGIN : CMD_RECAL, 16'd0};
    endfunction

    function automatic logic [4:0] last_bit(cmd_sel_e sel);
        return sel == SEL_POLL ? 5'd23 : 5'd7;
    endfunction

endpackage

// File: rtl/gc_joybus_tx_if.sv
// gc_joybus_tx_if: command handshake and bus-drive signals of gc_joybus_tx
// master: requester (drives cmd_valid/cmd_sel/rumble); slave: the transmitter.
interface gc_joybus_tx_if;
    import gc_joybus_pkg::*;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_sel;
    logic       rumble;
    logic       tx_data;
    logic       tx_active;
    logic       tx_done;
    modport master (output cmd_valid, cmd_sel, rumble, input cmd_ready, tx_data, tx_active, tx_done);
    modport slave  (input cmd_valid, cmd_sel, rumble, output cmd_ready, tx_data, tx_active, tx_done);
endinterface

// File: rtl/gc_us_tick.sv
// gc_us_tick: CLK_PER_US prescaler producing a one-cycle tick at the end of each 1 us slot
// Ports: clk, rst (sync, active-high), restart (realign slot to next cycle), tick (out).
module gc_us_tick #(
    parameter int CLK_PER_US = 60
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(CLK_PER_US);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = cnt_q == W'(CLK_PER_US - 1);
        cnt_d = (restart || tick) ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/gc_joybus_tx.sv
// gc_joybus_tx: Joybus command transmitter serialising probe/origin/poll/recal frames
// Ports: clk, rst (sync, active-high), bus (gc_joybus_tx_if.slave: cmd_valid/cmd_ready/
// cmd_sel/rumble in handshake, tx_data/tx_active/tx_done bus drive).
// Config macro GC_JOYBUS_RUMBLE_EN: send the latched rumble bit as the last poll bit.
module gc_joybus_tx
    import gc_joybus_pkg::*;
#(
    parameter int         CLK_PER_US = 60,
    parameter logic [7:0] POLL_MODE  = 8'h03,
    parameter int         GUARD_US   = 200
) (
    input logic            clk,
    input logic            rst,
    gc_joybus_tx_if.slave  bus
);
    localparam int GW = GUARD_US > 1 ? $clog2(GUARD_US) : 1;

    state_e        state_q, state_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [4:0]    bit_q, bit_d;
    logic [23:0]   sr_q, sr_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          done_q, done_d;
    logic          tick, accept, rum_bit, act;
    logic [3:0]    pat;

    assign accept = bus.cmd_valid && state_q == ST_IDLE;

`ifdef GC_JOYBUS_RUMBLE_EN
    assign rum_bit = bus.rumble;
`else
    assign rum_bit = bus.rumble & 1'b0;
`endif

    // Restarting on accept aligns the first quarter to start the cycle after accept.
    gc_us_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            qtr_q   <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            gcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = ST_SEND;
                qtr_d   = '0;
                sr_d    = frame_word(cmd_sel_e'(bus.cmd_sel), POLL_MODE, rum_bit);
                bit_d   = last_bit(cmd_sel_e'(bus.cmd_sel));
            end
            ST_SEND: if (tick) begin
                qtr_d = qtr_q == 2'd3 ? 2'd0 : qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    state_d = bit_q == 5'd0 ? ST_STOP : ST_SEND;
                    bit_d   = bit_q == 5'd0 ? bit_q : bit_q - 5'd1;
                    sr_d    = {sr_q[22:0], 1'b0};
                end
            end
            ST_STOP: if (tick) begin
                qtr_d = qtr_q == 2'd3 ? 2'd0 : qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    done_d  = 1'b1;
                    gcnt_d  = '0;
                    state_d = GUARD_US == 0 ? ST_IDLE : ST_GUARD;
                end
            end
            default: if (tick) begin
                gcnt_d  = gcnt_q == GW'(GUARD_US - 1) ? '0 : gcnt_q + GW'(1);
                state_d = gcnt_q == GW'(GUARD_US - 1) ? ST_IDLE : ST_GUARD;
            end
        endcase
    end

    // ~qtr_q selects pattern bit 3 for quarter 0 through bit 0 for quarter 3.
    always_comb begin
        act           = state_q == ST_SEND || state_q == ST_STOP;
        pat           = state_q == ST_STOP ? Q_STOP : (sr_q[23] ? Q_BIT1 : Q_BIT0);
        bus.tx_active = act;
        bus.tx_data   = act ? pat[~qtr_q] : 1'b1;
        bus.cmd_ready = state_q == ST_IDLE;
        bus.tx_done   = done_q;
    end

endmodule

// File: tb/tb_gc_joybus_tx.sv
// tb_gc_joybus_tx: randomized directed bench comparing three gc_joybus_tx configurations to a frame model
module tb_gc_joybus_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int cpu[3] = '{4, 2, 60};
    int gu[3]  = '{2, 0, 0};

    logic       valid[3];
    logic       rum[3];
    logic [1:0] sel[3];
    logic       d[3], a[3], dn[3], rdy[3];

    gc_joybus_tx_if bus0 ();
    gc_joybus_tx_if bus1 ();
    gc_joybus_tx_if bus2 ();

    gc_joybus_tx #(.CLK_PER_US(4),  .GUARD_US(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    gc_joybus_tx #(.CLK_PER_US(2),  .GUARD_US(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    gc_joybus_tx #(.CLK_PER_US(60), .GUARD_US(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    assign bus0.cmd_valid = valid[0];
    assign bus0.cmd_sel   = sel[0];
    assign bus0.rumble    = rum[0];
    assign bus1.cmd_valid = valid[1];
    assign bus1.cmd_sel   = sel[1];
    assign bus1.rumble    = rum[1];
    assign bus2.cmd_valid = valid[2];
    assign bus2.cmd_sel   = sel[2];
    assign bus2.rumble    = rum[2];
    assign d[0] = bus0.tx_data;  assign a[0] = bus0.tx_active; assign dn[0] = bus0.tx_done; assign rdy[0] = bus0.cmd_ready;
    assign d[1] = bus1.tx_data;  assign a[1] = bus1.tx_active; assign dn[1] = bus1.tx_done; assign rdy[1] = bus1.cmd_ready;
    assign d[2] = bus2.tx_data;  assign a[2] = bus2.tx_active; assign dn[2] = bus2.tx_done; assign rdy[2] = bus2.cmd_ready;

    typedef logic [7:0] bytes_t[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command bytes as seen on the wire, default POLL_MODE 0x03.
    function automatic bytes_t model_bytes(input logic [1:0] s, input logic r);
        logic rb;
`ifdef GC_JOYBUS_RUMBLE_EN
        rb = r;
`else
        rb = 1'b0 & r;
`endif
        case (s)
            2'd0:    return '{8'h00};
            2'd1:    return '{8'h41};
            2'd2:    return '{8'h40, 8'h03, {7'd0, rb}};
            default: return '{8'h42};
        endcase
    endfunction

    // Sends one command on DUT k starting at a negedge where cmd_ready is expected high,
    // records the driven waveform until tx_done, then follows the guard until cmd_ready.
    // Returns at the negedge of the cycle in which cmd_ready is high again.
    task automatic send(input int k, input logic [1:0] s, input logic r, input bit jit, input bit hold, input string tag);
        int     c = cpu[k];
        bytes_t bq;
        logic   expw[$];
        logic   got[$];
        logic   lv[4];
        logic [23:0] dec = '0, ew = '0;
        int     cyc = 0, busy = 0, errs = 0, g = 0, gap_bad = 0, idx;
        bit     fin = 0;
        bq = model_bytes(s, r);
        foreach (bq[j]) begin
            ew = {ew[15:0], bq[j]};
            for (int b = 7; b >= 0; b--) begin
                lv = bq[j][b] ? '{1'b0, 1'b1, 1'b1, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b1};
                for (int q = 0; q < 4; q++) for (int t = 0; t < c; t++) expw.push_back(lv[q]);
            end
        end
        lv = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int q = 0; q < 4; q++) for (int t = 0; t < c; t++) expw.push_back(lv[q]);
        chk({tag, "_ready_before"}, {31'd0, rdy[k]}, 32'd1);
        valid[k] = 1'b1;
        sel[k]   = s;
        rum[k]   = r;
        @(posedge clk);
        @(negedge clk);
        if (!hold) valid[k] = 1'b0;
        chk({tag, "_start_act_data"}, {30'd0, a[k], d[k]}, 32'b10);
        while (!fin && cyc < 20000) begin
            if (dn[k]) begin
                fin = 1;
                chk({tag, "_active_at_done"}, {31'd0, a[k]}, 32'd0);
            end else begin
                if (a[k]) begin
                    got.push_back(d[k]);
                    if (rdy[k]) busy++;
                end
                if (jit) begin
                    sel[k] = 2'($urandom_range(0, 3));
                    rum[k] = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                cyc++;
            end
        end
        chk({tag, "_done_seen"}, {31'd0, fin}, 32'd1);
        chk({tag, "_active_len"}, got.size(), expw.size());
        chk({tag, "_ready_in_frame"}, busy, 0);
        for (int i = 0; i < got.size() && i < expw.size(); i++) if (got[i] !== expw[i]) errs++;
        chk({tag, "_wave_errs"}, errs, 0);
        for (int i = 0; i < bq.size() * 8; i++) begin
            idx = i * 4 * c + c;
            dec = {dec[22:0], idx < got.size() ? got[idx] : 1'bx};
        end
        chk({tag, "_decoded"}, {8'd0, dec}, {8'd0, ew});
        while (!rdy[k] && g < 20000) begin
            @(negedge clk);
            g++;
            if (a[k] !== 1'b0 || d[k] !== 1'b1 || dn[k] !== 1'b0) gap_bad++;
        end
        chk({tag, "_ready_delay"}, g, gu[k] * c);
        chk({tag, "_guard_idle"}, gap_bad, 0);
    endtask

    initial begin
        logic [1:0] s;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            sel[k]   = 2'd0;
            rum[k]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_data_%0d", k), {31'd0, d[k]}, 32'd1);
            chk($sformatf("reset_active_%0d", k), {31'd0, a[k]}, 32'd0);
            chk($sformatf("reset_done_%0d", k), {31'd0, dn[k]}, 32'd0);
            chk($sformatf("reset_ready_%0d", k), {31'd0, rdy[k]}, 32'd1);
        end
        rst = 1'b0;
        @(negedge clk);

        send(0, 2'd0, 1'b0, 0, 0, "probe");
        send(0, 2'd2, 1'b1, 0, 0, "poll_rumble");
        send(0, 2'd2, 1'b0, 0, 0, "poll_norumble");

        // Origin with inputs toggling every cycle and cmd_valid held through the frame.
        send(0, 2'd1, 1'b0, 1, 1, "latch");
        valid[0] = 1'b0;
        @(negedge clk);
        chk("latch_no_second_accept", {31'd0, a[0]}, 32'd0);

        // Reset in cycle 50 of a poll frame.
        valid[0] = 1'b1; sel[0] = 2'd2; rum[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (49) @(negedge clk);
        chk("midreset_active_before", {31'd0, a[0]}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_active", {31'd0, a[0]}, 32'd0);
        chk("midreset_data", {31'd0, d[0]}, 32'd1);
        chk("midreset_ready", {31'd0, rdy[0]}, 32'd1);
        chk("midreset_done", {31'd0, dn[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 2'd0, 1'b0, 0, 0, "probe_after_reset");

        send(1, 2'd3, 1'b0, 0, 0, "recal_c2");
        send(2, 2'd3, 1'b1, 0, 0, "recal_c60");

        // Back-to-back: each frame begins the cycle after cmd_ready, so the idle run
        // is the 8 guard cycles (starting with the tx_done cycle) plus the accept cycle.
        for (int i = 0; i < 4; i++) begin
            s = i[0] ? 2'd2 : 2'd0;
            send(0, s, 1'($urandom_range(0, 1)), 0, 1, $sformatf("b2b_%0d", i));
        end
        valid[0] = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send(0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, 0, $sformatf("rand_%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
